// File: rtl/key_serial_loader.sv
// Serial key loader for the RLL-locked netlist: receives KEY_W bits MSB first plus an
// even-parity bit, then commits the key to a held bus. Retries are limited, then the block locks out.
module key_serial_loader #(
  parameter int unsigned KEY_W     = 32,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             sdi,
  input  logic             sdi_valid,
  output logic             sdi_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_armed,
  output logic             load_err,
  output logic             lockout,
  output logic             busy
);

  localparam int unsigned BIT_W  = $clog2(KEY_W + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam int unsigned FAIL_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_ARMED,
    ST_ERROR
  } state_e;

  state_e             state_q, state_d;
  logic [KEY_W-1:0]   shadow_q, shadow_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [FAIL_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic               parity_q, parity_d;
  logic               sdi_ready_q, sdi_ready_d;
  logic [KEY_W-1:0]   key_out_q, key_out_d;
  logic               key_armed_q, key_armed_d;
  logic               load_err_q, load_err_d;
  logic               lockout_q, lockout_d;
  logic               busy_q, busy_d;
  logic               beat;

  // sdi_ready_q is high exactly while the state register holds LOAD
  assign beat = sdi_valid & sdi_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      bit_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      parity_q    <= 1'b0;
      sdi_ready_q <= 1'b0;
      key_out_q   <= '0;
      key_armed_q <= 1'b0;
      load_err_q  <= 1'b0;
      lockout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      parity_q    <= parity_d;
      sdi_ready_q <= sdi_ready_d;
      key_out_q   <= key_out_d;
      key_armed_q <= key_armed_d;
      load_err_q  <= load_err_d;
      lockout_q   <= lockout_d;
      busy_q      <= busy_d;
    end
  end

  // Next state plus shift/count datapath
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    bit_cnt_d  = bit_cnt_q;
    idle_cnt_d = idle_cnt_q;
    fail_cnt_d = fail_cnt_q;
    parity_d   = parity_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d    = ST_LOAD;
          shadow_d   = '0;
          bit_cnt_d  = '0;
          idle_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (beat) begin
          idle_cnt_d = '0;
          if (bit_cnt_q == BIT_W'(KEY_W)) begin
            parity_d = sdi;
            state_d  = ST_CHECK;
          end else begin
            shadow_d  = {shadow_q[KEY_W-2:0], sdi};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          if (idle_cnt_q != IDLE_W'(TIMEOUT)) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
          // this idle cycle is the TIMEOUT-th in a row
          if (idle_cnt_q >= IDLE_W'(TIMEOUT - 1)) begin
            state_d    = ST_ERROR;
            fail_cnt_d = fail_cnt_q + FAIL_W'(1);
          end
        end
      end
      ST_CHECK: begin
        if ((^shadow_q) == parity_q) begin
          state_d = ST_ARMED;
        end else begin
          state_d    = ST_ERROR;
          fail_cnt_d = fail_cnt_q + FAIL_W'(1);
        end
      end
      ST_ARMED: begin
        state_d = ST_ARMED;
      end
      ST_ERROR: begin
        if (load_start && (fail_cnt_q < FAIL_W'(MAX_RETRY))) begin
          state_d    = ST_LOAD;
          bit_cnt_d  = '0;
          idle_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_ERROR || (state_q == ST_ERROR && state_d == ST_LOAD)) begin
      shadow_d = '0;
    end
  end

  // Registered outputs follow the next state so they line up with state_q
  always_comb begin
    sdi_ready_d = (state_d == ST_LOAD);
    busy_d      = (state_d == ST_LOAD) || (state_d == ST_CHECK);
    key_armed_d = (state_d == ST_ARMED);
    load_err_d  = (state_d == ST_ERROR);
    lockout_d   = lockout_q || (fail_cnt_d == FAIL_W'(MAX_RETRY));
    key_out_d   = key_out_q;
    if (state_q == ST_CHECK && state_d == ST_ARMED) begin
      key_out_d = shadow_q;
    end
    if (state_d == ST_ERROR) begin
      key_out_d = '0;
    end
  end

  assign sdi_ready = sdi_ready_q;
  assign key_out   = key_out_q;
  assign key_armed = key_armed_q;
  assign load_err  = load_err_q;
  assign lockout   = lockout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_key_serial_loader.sv
// Directed bench for key_serial_loader: vector table of full loads plus corner sequences.
module tb_key_serial_loader;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic        sdi;
  logic        sdi_valid;
  logic        sdi_ready;
  logic [31:0] key_out;
  logic        key_armed;
  logic        load_err;
  logic        lockout;
  logic        busy;

  int checks;
  int errors;

  key_serial_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .sdi        (sdi),
    .sdi_valid  (sdi_valid),
    .sdi_ready  (sdi_ready),
    .key_out    (key_out),
    .key_armed  (key_armed),
    .load_err   (load_err),
    .lockout    (lockout),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] key;
    logic        par;
    logic        exp_armed;
    logic        exp_err;
    logic [31:0] exp_key;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    load_start = 1'b0;
    sdi        = 1'b0;
    sdi_valid  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic beat(input logic b);
    sdi       = b;
    sdi_valid = 1'b1;
    tick();
    sdi_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    sdi_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_bits(input logic [31:0] k, input int nbits);
    for (int i = 31; i > 31 - nbits; i--) beat(k[i]);
  endtask

  task automatic send_key(input logic [31:0] k, input logic p);
    send_bits(k, 32);
    beat(p);
  endtask

  initial begin
    logic [31:0] k;
    logic [31:0] held;
    checks = 0;
    errors = 0;

    vecs[0] = '{32'hA5C3_0F96, 1'b0, 1'b1, 1'b0, 32'hA5C3_0F96};
    vecs[1] = '{32'hA5C3_0F96, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
    vecs[2] = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF};
    vecs[4] = '{32'h0000_0001, 1'b1, 1'b1, 1'b0, 32'h0000_0001};
    vecs[5] = '{32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h0000_0000};
    vecs[6] = '{32'h8000_0000, 1'b1, 1'b1, 1'b0, 32'h8000_0000};

    do_reset();
    chk("rst_key_out", key_out, 32'h0);
    chk("rst_flags", {27'h0, sdi_ready, key_armed, load_err, lockout, busy}, 32'h0);

    // Vector table: back-to-back full loads
    for (int v = 0; v < 7; v++) begin
      do_reset();
      start();
      chk($sformatf("v%0d_ready", v), {31'h0, sdi_ready}, 32'h1);
      send_key(vecs[v].key, vecs[v].par);
      chk($sformatf("v%0d_check_busy", v), {30'h0, busy, key_armed}, 32'h2);
      chk($sformatf("v%0d_check_ready", v), {31'h0, sdi_ready}, 32'h0);
      tick();
      chk($sformatf("v%0d_armed", v), {31'h0, key_armed}, {31'h0, vecs[v].exp_armed});
      chk($sformatf("v%0d_err", v), {31'h0, load_err}, {31'h0, vecs[v].exp_err});
      chk($sformatf("v%0d_key", v), key_out, vecs[v].exp_key);
      chk($sformatf("v%0d_busy", v), {31'h0, busy}, 32'h0);
    end

    // Bad parity then retry from ERROR
    do_reset();
    start();
    send_key(32'hA5C3_0F96, 1'b1);
    tick();
    chk("retry_err", {30'h0, load_err, key_armed}, 32'h2);
    start();
    chk("retry_err_clear", {30'h0, load_err, sdi_ready}, 32'h1);
    send_key(32'hA5C3_0F96, 1'b0);
    tick();
    chk("retry_armed", {30'h0, key_armed, load_err}, 32'h2);
    chk("retry_key", key_out, 32'hA5C3_0F96);

    // Gapped stream: max legal gap first, then random gaps
    do_reset();
    k = 32'h3C5A_9966;
    start();
    load_start = 1'b1;
    for (int i = 31; i >= 0; i--) begin
      gap(i == 31 ? 254 : int'($urandom_range(0, 254)));
      load_start = 1'b0;
      beat(k[i]);
    end
    gap(int'($urandom_range(0, 254)));
    beat(1'b0);
    tick();
    chk("gap_armed", {31'h0, key_armed}, 32'h1);
    chk("gap_key", key_out, 32'h3C5A_9966);

    // Timeout boundary: 254 idle cycles survive, the 255th aborts
    do_reset();
    start();
    send_bits(32'hA5C3_0F96, 11);
    gap(254);
    chk("to_still_busy", {30'h0, busy, load_err}, 32'h2);
    gap(1);
    chk("to_err", {30'h0, busy, load_err}, 32'h1);
    chk("to_ready", {31'h0, sdi_ready}, 32'h0);
    chk("to_key", key_out, 32'h0);

    // Lockout after three failures
    do_reset();
    for (int f = 0; f < 3; f++) begin
      start();
      send_key(32'hA5C3_0F96, 1'b1);
      tick();
      chk($sformatf("lk_fail%0d", f), {30'h0, lockout, load_err}, (f == 2) ? 32'h3 : 32'h1);
    end
    start();
    tick();
    chk("lk_ignored", {29'h0, sdi_ready, busy, load_err}, 32'h1);
    chk("lk_sticky", {31'h0, lockout}, 32'h1);

    // Reset mid-load, then a fresh load
    do_reset();
    start();
    send_bits(32'hA5C3_0F96, 21);
    chk("mid_busy", {30'h0, busy, sdi_ready}, 32'h3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", {27'h0, sdi_ready, key_armed, load_err, lockout, busy}, 32'h0);
    chk("mid_rst_key", key_out, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    start();
    send_key(32'h1234_5678, 1'b1);
    tick();
    chk("mid_fresh_armed", {31'h0, key_armed}, 32'h1);
    chk("mid_fresh_key", key_out, 32'h1234_5678);

    // Load_start mid-load is ignored; post-arm immunity
    do_reset();
    start();
    send_bits(32'hA5C3_0F96, 5);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 26; i >= 0; i--) beat(k[i] ^ k[i] ^ 32'hA5C3_0F96 >> i);
    beat(1'b0);
    tick();
    chk("ls_mid_key", key_out, 32'hA5C3_0F96);
    held = key_out;
    for (int c = 0; c < 100; c++) begin
      load_start = 1'(($urandom_range(0, 3)) == 0);
      sdi        = 1'($urandom_range(0, 1));
      sdi_valid  = 1'($urandom_range(0, 1));
      tick();
      chk("imm_key", key_out, held);
      chk("imm_ready", {30'h0, sdi_ready, key_armed}, 32'h1);
    end
    load_start = 1'b0;
    sdi_valid  = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
